// File: rtl/bram_burst_if.sv
// Channel-side bus of bram_burst_controller: requesters drive the master modport, the controller uses slave.
// Handshake: req is a level, held until grant; while wdata_req is high the granted channel's wdata is consumed at each rising edge and the next word is due in the following cycle.
interface bram_burst_if #(
    parameter int NUM_CH             = 2,
    parameter int ADDR_WIDTH         = 16,
    parameter int DATA_WIDTH         = 32,
    parameter int BLOCK_OFFSET_WIDTH = 5
);
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0]            rw;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*DATA_WIDTH-1:0] wdata;
    logic [NUM_CH-1:0]            grant;
    logic                         wdata_req;
    logic [DATA_WIDTH-1:0]        rdata;
    logic                         rdata_valid;
    logic [BLOCK_OFFSET_WIDTH-1:0] rdata_offset;
    logic [NUM_CH-1:0]            done;

    modport master (
        output req, rw, addr, wdata,
        input  grant, wdata_req, rdata, rdata_valid, rdata_offset, done
    );

    modport slave (
        input  req, rw, addr, wdata,
        output grant, wdata_req, rdata, rdata_valid, rdata_offset, done
    );
endinterface

// File: rtl/bram_burst_controller.sv
// Round-robin block-burst arbiter in front of a single BRAM port; read data is re-timed through a READ_LATENCY-deep pipe.
// Optional macro BRAM_BURST_CRITICAL_WORD_FIRST_EN: reads start at the requested offset and wrap inside the block.
module bram_burst_controller #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int NUM_CH             = 2,
    parameter int READ_LATENCY       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_burst_if.slave           bus,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    input  logic [DATA_WIDTH-1:0] douta,
    output logic [1:0]            fsm_state
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
        {{(ADDR_WIDTH-BLOCK_OFFSET_WIDTH){1'b1}}, {BLOCK_OFFSET_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]               rr_ptr;
    logic [CH_W-1:0]               gidx;
    logic [CH_W-1:0]               pick_idx;
    logic                          pick_found;
    logic [ADDR_WIDTH-1:0]         addr_sel;
    logic [DATA_WIDTH-1:0]         wdata_sel;
    logic [ADDR_WIDTH-1:0]         base;
    logic [BLOCK_OFFSET_WIDTH-1:0] start_off;
    logic [BLOCK_OFFSET_WIDTH-1:0] cnt;
    logic [BLOCK_OFFSET_WIDTH-1:0] cur_off;
    logic                          rd_last;

    logic                          pipe_v    [READ_LATENCY];
    logic                          pipe_last [READ_LATENCY];
    logic [BLOCK_OFFSET_WIDTH-1:0] pipe_off  [READ_LATENCY];

    // Search starts one past the last owner so every requester is served in turn.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + 1 + i) % NUM_CH;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(idx);
            end
        end
    end

    assign addr_sel  = bus.addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_sel = bus.wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    assign cur_off   = start_off + cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (pick_found) state_nxt = bus.rw[pick_idx] ? WRITE : READ;
            READ, WRITE: if (&cnt) state_nxt = DONE;
            DONE:        if (|bus.done) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    assign bus.wdata_req = (state == WRITE);
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= CH_W'(NUM_CH - 1);
            gidx             <= '0;
            base             <= '0;
            start_off        <= '0;
            cnt              <= '0;
            rd_last          <= 1'b0;
            ena              <= 1'b0;
            wea              <= 1'b0;
            addra            <= '0;
            dina             <= '0;
            bus.grant        <= '0;
            bus.done         <= '0;
            bus.rdata        <= '0;
            bus.rdata_valid  <= 1'b0;
            bus.rdata_offset <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_last[i] <= 1'b0;
                pipe_off[i]  <= '0;
            end
        end else begin
            state    <= state_nxt;
            ena      <= 1'b0;
            wea      <= 1'b0;
            rd_last  <= 1'b0;
            bus.done <= '0;

            // Stage 0 tags the address on addra this cycle; the last stage lines up with douta.
            pipe_v[0]    <= ena & ~wea;
            pipe_last[0] <= rd_last;
            pipe_off[0]  <= addra[BLOCK_OFFSET_WIDTH-1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_off[i]  <= pipe_off[i-1];
            end
            bus.rdata_valid <= pipe_v[READ_LATENCY-1];
            if (pipe_v[READ_LATENCY-1]) begin
                bus.rdata        <= douta;
                bus.rdata_offset <= pipe_off[READ_LATENCY-1];
                if (pipe_last[READ_LATENCY-1]) bus.done <= bus.grant;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        bus.grant <= NUM_CH'(1) << pick_idx;
                        gidx      <= pick_idx;
                        rr_ptr    <= pick_idx;
                        base      <= addr_sel & BASE_MASK;
                        cnt       <= '0;
`ifdef BRAM_BURST_CRITICAL_WORD_FIRST_EN
                        start_off <= addr_sel[BLOCK_OFFSET_WIDTH-1:0];
`else
                        start_off <= '0;
`endif
                    end
                end
                READ: begin
                    ena     <= 1'b1;
                    addra   <= base | ADDR_WIDTH'(cur_off);
                    rd_last <= &cnt;
                    cnt     <= cnt + 1'b1;
                end
                WRITE: begin
                    ena   <= 1'b1;
                    wea   <= 1'b1;
                    addra <= base | ADDR_WIDTH'(cnt);
                    dina  <= wdata_sel;
                    cnt   <= cnt + 1'b1;
                    // The last word reaches the BRAM next cycle, together with done.
                    if (&cnt) bus.done <= bus.grant;
                end
                DONE: begin
                    if (|bus.done) bus.grant <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_burst_controller.sv
// Directed bench for bram_burst_controller: burst table on a READ_LATENCY=1 instance plus hand sequences
// for READ_LATENCY=3 timing, reset mid-write and two-channel round-robin.
module tb_bram_burst_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef BRAM_BURST_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    // ---------------- DUT, READ_LATENCY = 1 ----------------
    bram_burst_if #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BLOCK_OFFSET_WIDTH(5)) bus ();
    logic        ena, wea;
    logic [15:0] addra;
    logic [31:0] dina, douta;
    logic [1:0]  fsm_state;

    bram_burst_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5),
                            .NUM_CH(2), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta), .fsm_state(fsm_state)
    );

    // BRAM model: unwritten words read back as their own address
    logic [31:0] wmem   [65536];
    bit          wvalid [65536];
    always @(posedge clk) begin
        if (ena && wea) begin
            wmem[addra]   <= dina;
            wvalid[addra] <= 1'b1;
        end
        douta <= wvalid[addra] ? wmem[addra] : {16'h0, addra};
    end

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return wvalid[a] ? wmem[a] : {16'h0, a};
    endfunction

    // ---------------- DUT, READ_LATENCY = 3 ----------------
    bram_burst_if #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BLOCK_OFFSET_WIDTH(5)) bus3 ();
    logic        ena3, wea3;
    logic [15:0] addra3;
    logic [31:0] dina3, douta3;
    logic [1:0]  fsm_state3;
    logic [31:0] dq3 [3];

    bram_burst_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5),
                            .NUM_CH(2), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .ena(ena3), .wea(wea3), .addra(addra3),
        .dina(dina3), .douta(douta3), .fsm_state(fsm_state3)
    );

    always @(posedge clk) begin
        dq3[0] <= {16'h0, addra3};
        dq3[1] <= dq3[0];
        dq3[2] <= dq3[1];
    end
    assign douta3 = dq3[2];

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [65536];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          ch;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wb;
        logic [15:0] eb;
        logic [4:0]  es;
    } vec_t;
    vec_t vecs [7];

    // One burst on the READ_LATENCY=1 instance; inputs are scrambled right after grant.
    task automatic run_burst(input int ch, input logic wr, input logic [15:0] a, input logic [31:0] wb,
                             input logic [15:0] eb, input logic [4:0] es, input string tag);
        int   fe, fv, lv, nv, nd, nw;
        bit   got, fin;
        logic [4:0] eo;
        bus.req        = '0;
        bus.req[ch]    = 1'b1;
        bus.rw[ch]     = wr;
        bus.addr[ch*16 +: 16] = a;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.grant != '0) got = 1'b1;
        end
        check({tag, " grant"}, 64'(bus.grant), 64'(2'b01 << ch));
        bus.req = '0;
        bus.rw  = ~bus.rw;
        bus.addr = $urandom;
        if (!got) return;
        fe = -1; fv = -1; lv = -1; nv = 0; nd = 0; nw = 0; fin = 1'b0;
        for (int t = 0; t < 100 && !fin; t++) begin
            bus.wdata = {$urandom, $urandom};
            if (bus.wdata_req) begin
                bus.wdata[ch*32 +: 32] = wb + nw;
                nw++;
            end
            if (ena && fe < 0) fe = t;
            if (bus.rdata_valid) begin
                eo = es + 5'(nv);
                check($sformatf("%s rdata[%0d]", tag, nv), 64'(bus.rdata), 64'(ref_mem[eb | {11'h0, eo}]));
                check($sformatf("%s offset[%0d]", tag, nv), 64'(bus.rdata_offset), 64'(eo));
                if (fv < 0) fv = t;
                lv = t;
                nv++;
            end
            if (bus.done != '0) begin
                nd++;
                fin = 1'b1;
                check({tag, " done owner"}, 64'(bus.done), 64'(2'b01 << ch));
                if (wr)
                    check({tag, " done with last write"}, {46'h0, ena, wea, addra}, {46'h0, 2'b11, eb + 16'd31});
                else
                    check({tag, " done with last word"}, {32'h0, 31'(nv), bus.rdata_valid}, {32'h0, 31'd32, 1'b1});
            end
            @(negedge clk);
        end
        check({tag, " done count"}, 64'(nd), 64'd1);
        check({tag, " after done"}, {57'h0, bus.grant, ena, wea, fsm_state, bus.done}, 64'h0);
        if (wr) begin
            check({tag, " wdata_req cycles"}, 64'(nw), 64'd32);
            for (int k = 0; k < 32; k++) begin
                check($sformatf("%s mem[%0h]", tag, eb + 16'(k)), 64'(mem_rd(eb + 16'(k))), 64'(wb + k));
                ref_mem[eb + 16'(k)] = wb + k;
            end
        end else begin
            check({tag, " valid count"}, 64'(nv), 64'd32);
            check({tag, " valid contiguous"}, 64'(lv - fv), 64'd31);
            check({tag, " first valid delay"}, 64'(fv - fe), 64'd2);
        end
    endtask

    initial begin
        int   fe, fv, lv, nv, nd, j, ng, zr;
        bit   got;
        logic [1:0] prev;
        logic [1:0] gseq [3];
        int         gaps [3];

        for (int i = 0; i < 65536; i++) ref_mem[i] = {16'h0, 16'(i)};
        vecs[0] = '{0, 1'b0, 16'h0040, 32'h0,    16'h0040, 5'd0};
        vecs[1] = '{1, 1'b0, 16'h0047, 32'h0,    16'h0040, CWF ? 5'd7 : 5'd0};
        vecs[2] = '{1, 1'b1, 16'h0100, 32'hA000, 16'h0100, 5'd0};
        vecs[3] = '{0, 1'b0, 16'h011C, 32'h0,    16'h0100, CWF ? 5'd28 : 5'd0};
        vecs[4] = '{0, 1'b1, 16'h0213, 32'h5500, 16'h0200, 5'd0};
        vecs[5] = '{1, 1'b0, 16'hFFFF, 32'h0,    16'hFFE0, CWF ? 5'd31 : 5'd0};
        vecs[6] = '{1, 1'b0, 16'h0205, 32'h0,    16'h0200, CWF ? 5'd5 : 5'd0};

        bus.req = '0; bus.rw = '0; bus.addr = '0; bus.wdata = '0;
        bus3.req = '0; bus3.rw = '0; bus3.addr = '0; bus3.wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {bus.grant, bus.done, bus.rdata_valid, bus.wdata_req, ena, wea, fsm_state,
                                bus.rdata_offset}, 15'h0);
        check("reset addra/dina", {addra, dina}, 48'h0);
        check("reset rdata", 64'(bus.rdata), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // READ_LATENCY = 3 read burst
        bus3.req = 2'b01; bus3.rw = 2'b00; bus3.addr = {16'h0, 16'h0080};
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus3.grant != '0) got = 1'b1;
        end
        check("rl3 grant", 64'(bus3.grant), 64'h1);
        bus3.req = '0;
        fe = -1; fv = -1; lv = -1; nv = 0; nd = 0;
        for (int t = 0; t < 100 && nd == 0; t++) begin
            if (ena3 && fe < 0) fe = t;
            if (bus3.rdata_valid) begin
                check($sformatf("rl3 rdata[%0d]", nv), 64'(bus3.rdata), 64'(32'h80 + nv));
                if (fv < 0) fv = t;
                lv = t;
                nv++;
            end
            if (bus3.done != '0) nd++;
            @(negedge clk);
        end
        check("rl3 valid count", 64'(nv), 64'd32);
        check("rl3 valid contiguous", 64'(lv - fv), 64'd31);
        check("rl3 first valid delay", 64'(fv - fe), 64'd4);
        check("rl3 done count", 64'(nd), 64'd1);
        check("rl3 after done", {59'h0, bus3.grant, ena3, wea3, fsm_state3}, 64'h0);

        // table of bursts
        for (int v = 0; v < 7; v++)
            run_burst(vecs[v].ch, vecs[v].wr, vecs[v].addr, vecs[v].wb, vecs[v].eb, vecs[v].es,
                      $sformatf("vec%0d", v));

        // reset while the 11th write word is on the BRAM port
        bus.req = 2'b01; bus.rw = 2'b01; bus.addr = {16'h0, 16'h0300};
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.grant != '0) got = 1'b1;
        end
        check("rstw grant", 64'(bus.grant), 64'h1);
        bus.req = '0;
        j = 0;
        for (int t = 0; t < 40 && j < 11; t++) begin
            if (bus.wdata_req) begin
                bus.wdata[31:0] = 32'hB000 + j;
                j++;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("rstw outputs", {bus.grant, bus.done, bus.rdata_valid, bus.wdata_req, ena, wea, fsm_state}, 10'h0);
        check("rstw addra/dina", {addra, dina}, 48'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.done != '0) nd++;
        end
        check("rstw no done", 64'(nd), 64'd0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("rstw mem[%0d]", k), 64'(mem_rd(16'h0300 + 16'(k))), 64'(32'hB000 + k));
            ref_mem[16'h0300 + 16'(k)] = 32'hB000 + k;
        end
        check("rstw word 10 unwritten", 64'(mem_rd(16'h030A)), 64'h030A);
        run_burst(1, 1'b1, 16'h0300, 32'hC000, 16'h0300, 5'd0, "post_rst");

        // round-robin with both channels requesting continuously
        bus.req = 2'b11; bus.rw = 2'b00; bus.addr = {16'h0500, 16'h0400};
        gseq[0] = '0; gseq[1] = '0; gseq[2] = '0;
        gaps[0] = -1; gaps[1] = -1; gaps[2] = -1;
        ng = 0; zr = 0; prev = '0;
        for (int t = 0; t < 300 && ng < 3; t++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                if (prev == '0) begin
                    gseq[ng] = bus.grant;
                    gaps[ng] = zr;
                    ng++;
                end
                zr = 0;
            end else begin
                zr++;
            end
            prev = bus.grant;
        end
        bus.req = '0;
        check("rr grant 1", 64'(gseq[0]), 64'h1);
        check("rr grant 2", 64'(gseq[1]), 64'h2);
        check("rr grant 3", 64'(gseq[2]), 64'h1);
        check("rr idle gap 2", 64'(gaps[1]), 64'd1);
        check("rr idle gap 3", 64'(gaps[2]), 64'd1);
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.grant == '0 && fsm_state == 2'd0) got = 1'b1;
        end
        check("rr drained to idle", 64'(got), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
